// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Defaults match the 32 x 32-bit configuration; the top and the scoreboard
// import this package for their parameter defaults.
package regfile_mp_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks a pending producer.
// Writes clear their address, a reserve sets its address, and a reserve wins
// over a write to the same address in the same cycle. Register 0 is never busy.
// busy_cnt is the registered population count of the busy bits.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] busy_q;
    logic [ADDR_W:0]  busy_cnt_d;
    logic [ADDR_W:0]  busy_cnt_q;

    // Next busy vector: writes clear first, then a nonzero reserve sets.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            busy_d[wr_addr[i*ADDR_W +: ADDR_W]] =
                wr_en[i] ? 1'b0 : busy_d[wr_addr[i*ADDR_W +: ADDR_W]];
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d[rsv_addr] = busy_d[rsv_addr];
        end
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        busy_cnt_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[j]};
        end
    end

    // Scoreboard state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a busy-bit scoreboard.
// Register 0 is hard-wired to zero. Reads are combinational from stored state;
// when two write ports target the same address the higher-index port wins.
// Optional build macro REGFILE_MP_BYPASS_EN forwards same-cycle write data to
// matching read ports (and reports them not busy).
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_mp_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Next storage contents: ports applied in ascending order so the highest wins.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i]) begin
                mem_d[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
            end else begin
                mem_d[wr_addr[i*ADDR_W +: ADDR_W]] = mem_d[wr_addr[i*ADDR_W +: ADDR_W]];
            end
        end
        mem_d[0] = '0;
    end

    // Register storage, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read muxes: stored value and busy bit, optionally overridden by a
    // same-cycle write (suppressed while reset is asserted).
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
            rd_busy[k]                  = busy[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int i = 0; i < NUM_WR; i++) begin
                if (rst_n && wr_en[i] && (rd_addr[k*ADDR_W +: ADDR_W] != '0) &&
                    (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr[i*ADDR_W +: ADDR_W])) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                    rd_busy[k]                  = 1'b0;
                end else begin
                    rd_busy[k] = rd_busy[k];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [ADDR_W:0]          busy_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_busy [DEPTH];

    regfile_mp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int wa(input int p);
        return int'(wr_addr[p*ADDR_W +: ADDR_W]);
    endfunction

    function automatic int ra(input int k);
        return int'(rd_addr[k*ADDR_W +: ADDR_W]);
    endfunction

    // Expected read value: r0 is zero, otherwise stored value, or the last
    // matching enabled write port when forwarding is built in.
    function automatic logic [DATA_W-1:0] exp_rd(input int a);
        logic [DATA_W-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (BYPASS && rst_n)
            for (int i = 0; i < NUM_WR; i++)
                if (wr_en[i] && wa(i) == a) v = wr_data[i*DATA_W +: DATA_W];
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        logic b;
        if (a == 0) return 1'b0;
        b = m_busy[a];
        if (BYPASS && rst_n)
            for (int i = 0; i < NUM_WR; i++)
                if (wr_en[i] && wa(i) == a) b = 1'b0;
        return b;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of effects to the model.
    task automatic model_edge();
        for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i] && wa(i) != 0) m_mem[wa(i)] = wr_data[i*DATA_W +: DATA_W];
        for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i]) m_busy[wa(i)] = 1'b0;
        if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic set_wr(input int p, input bit en, input int a, input logic [DATA_W-1:0] d);
        wr_en[p]                    = en;
        wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wr_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rsv(input bit en, input int a);
        rsv_en   = en;
        rsv_addr = ADDR_W'(a);
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic check_now(input string tag);
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("%s_rd%0d", tag, k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_rd(ra(k))));
            check($sformatf("%s_busy%0d", tag, k), 64'(rd_busy[k]), 64'(exp_busy(ra(k))));
        end
        check({tag, "_cnt"}, 64'(busy_cnt), 64'(model_cnt()));
    endtask

    // Advance one cycle; inputs may change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        model_reset();
        set_rd(0, 1);
        set_rd(1, 7);
        tick();
        tick();
        check_now("por");
        check("por_cnt0", 64'(busy_cnt), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Reset mid-cycle wipes data immediately; writes during reset are dropped.
        set_wr(0, 1'b1, 1, 32'hABC12345);
        set_rsv(1'b1, 1);
        #1 check_now("pre_rst");
        tick();
        idle();
        #1 check("r1_written", 64'(rd_data[DATA_W-1:0]), 64'h0000_0000_ABC1_2345);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rst_rd_imm", 64'(rd_data[DATA_W-1:0]), 64'd0);
        check("rst_cnt_imm", 64'(busy_cnt), 64'd0);
        set_wr(1, 1'b1, 1, 32'h5555AAAA);
        set_rsv(1'b1, 2);
        #1 check_now("rst_hold");
        tick();
        check_now("rst_after_edge");
        idle();
        #3 rst_n = 1'b1;
        #1;

        // r0 ignores writes and reservations.
        set_rd(0, 0);
        set_wr(0, 1'b1, 0, 32'hABC12345);
        set_rsv(1'b1, 0);
        #1 check_now("r0_w");
        tick();
        idle();
        #1 check("r0_zero", 64'(rd_data[DATA_W-1:0]), 64'd0);
        check_now("r0_post");

        // Dual write, same address: port 1 wins; different addresses both land.
        set_wr(0, 1'b1, 2, 32'h30663220);
        set_wr(1, 1'b1, 2, 32'h12345678);
        tick();
        idle();
        set_rd(0, 2);
        #1 check("r2_port1", 64'(rd_data[DATA_W-1:0]), 64'h1234_5678);
        set_wr(0, 1'b1, 6, 32'h66666666);
        set_wr(1, 1'b1, 7, 32'h77777777);
        tick();
        idle();
        set_rd(0, 6);
        set_rd(1, 7);
        #1 check("r6", 64'(rd_data[DATA_W-1:0]), 64'h6666_6666);
        check("r7", 64'(rd_data[2*DATA_W-1:DATA_W]), 64'h7777_7777);
        check_now("dual");

        // Scoreboard sequence.
        set_rsv(1'b1, 3);
        tick();
        set_rsv(1'b1, 4);
        tick();
        set_rsv(1'b1, 4);
        tick();
        idle();
        set_rd(0, 3);
        set_rd(1, 4);
        #1 check("cnt2", 64'(busy_cnt), 64'd2);
        check("busy_r3", 64'(rd_busy), 64'b11);
        set_wr(0, 1'b1, 3, 32'h33333333);
        #1 check_now("w3_pre");
        tick();
        idle();
        #1 check("cnt1", 64'(busy_cnt), 64'd1);
        set_rsv(1'b1, 4);
        set_wr(1, 1'b1, 4, 32'h44444444);
        #1 check_now("rw4_pre");
        tick();
        idle();
        #1 check("r4_data", 64'(rd_data[2*DATA_W-1:DATA_W]), 64'h4444_4444);
        check("r4_busy", 64'(rd_busy[1]), 64'd1);
        check("cnt_r4", 64'(busy_cnt), 64'd1);

        // Same-cycle write/read of r5.
        set_rd(0, 5);
        set_wr(0, 1'b1, 5, 32'hDEADBEEF);
        #1 check("r5_same", 64'(rd_data[DATA_W-1:0]), BYPASS ? 64'hDEAD_BEEF : 64'd0);
        tick();
        idle();
        #1 check("r5_next", 64'(rd_data[DATA_W-1:0]), 64'hDEAD_BEEF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_RD; k++) set_rd(k, $urandom_range(DEPTH - 1, 0));
            for (int p = 0; p < NUM_WR; p++)
                set_wr(p, bit'($urandom_range(1, 0)), $urandom_range(DEPTH - 1, 0), $urandom());
            if ($urandom_range(3, 0) == 0) set_rd(0, wa(NUM_WR - 1));
            set_rsv(bit'($urandom_range(1, 0)), $urandom_range(DEPTH - 1, 0));
            #1 check_now("rand");
            tick();
        end
        idle();
        #1 check_now("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter: DATA_W, 32, register width in bits.
REQ-002 Parameter: DEPTH, 32, number of registers (power of two, >=4).
REQ-003 Parameter: NUM_RD, 2, read port count (1..4).
REQ-004 Parameter: NUM_WR, 2, write port count (1..2).
REQ-005 Derived constant: ADDR_W = clog2(DEPTH).
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, all state updates on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port 0 in LSBs.
REQ-010 rd_data  out  NUM_RD*DATA_W  packed read data.
REQ-011 rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register.
REQ-012 wr_en  in  NUM_WR  per-port write enable.
REQ-013 wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
REQ-014 wr_data  in  NUM_WR*DATA_W  packed write data.
REQ-015 rsv_en  in  1  reserve request: mark rsv_addr busy (pending producer).
REQ-016 rsv_addr  in  ADDR_W  register to reserve.
REQ-017 busy_cnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-018 Register 0 SHALL read as zero always; writes and reservations to address 0 SHALL be ignored.
REQ-019 Reads SHALL be combinational (zero latency) from stored state; a write becomes visible on the cycle after its rising edge.
REQ-020 A write with wr_en[i]=1 SHALL update register wr_addr[i] with wr_data[i] at the rising edge.
REQ-021 Two write ports to the same nonzero address in one cycle: highest-index port SHALL win.
REQ-022 A write SHALL clear the busy bit of its address at the same edge.
REQ-023 rsv_en=1 SHALL set the busy bit of rsv_addr at the edge; reserving an already-busy register SHALL leave it busy.
REQ-024 Reserve and write to the same address in one cycle: data SHALL update, busy SHALL end set (reserve wins).
REQ-025 busy_cnt SHALL equal the population count of busy bits, updated each edge, never exceeding DEPTH-1.
REQ-026 rd_busy[k] SHALL reflect stored busy bit of rd_addr[k]; address 0 always reports 0.

Reset
REQ-027 rst_n low SHALL immediately clear every register to 0, every busy bit to 0, busy_cnt to 0, independent of clk.
REQ-028 Writes/reserves coincident with reset assertion SHALL be discarded; first effective edge is the first rising clk after rst_n high.
REQ-029 With rst_n low, rd_data SHALL read 0 on every port and rd_busy SHALL be 0.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-031 With REGFILE_MP_BYPASS_EN: a read whose nonzero address matches an enabled same-cycle write SHALL return that wr_data (REQ-021 priority) and rd_busy 0.
REQ-032 Without REGFILE_MP_BYPASS_EN: reads SHALL return stored values only (REQ-019).

Structure
REQ-033 Shared package regfile_mp_pkg SHALL hold default DATA_W/DEPTH constants and the address/data typedefs.
REQ-034 The scoreboard (busy bits, busy_cnt) SHALL be a sub-module regfile_mp_scoreboard; storage and read muxing stay in the top.

Verification
REQ-035 Reset: 0xABC12345 to r1 then rst_n pulsed low mid-cycle -> rd_data 0 immediately, busy_cnt 0.
REQ-036 r0 write: wr_en[0]=1, addr 0, data 0xABC12345 -> next cycle rd_addr 0 reads 0x00000000.
REQ-037 Dual write: port0 r2=0x30663220, port1 r2=0x12345678 same edge -> r2 reads 0x12345678; different addrs both land.
REQ-038 Scoreboard: reserve r3, r4 -> busy_cnt 2, rd_busy set; write r3 -> busy_cnt 1; reserve+write r4 same cycle -> r4 still busy, data updated.
REQ-039 Bypass build: write r5=0xDEADBEEF with rd_addr r5 same cycle -> reads 0xDEADBEEF that cycle; non-bypass build reads old value until next edge.
REQ-040 Parameter sweep: DEPTH=16, NUM_RD=4, DATA_W=64 -> REQ-035..038 pass with rescaled values.
